// File: rtl/flag_unit_if.sv
// Flag-unit bus: ALU/decoder controls toward the flag register plus its registered outputs.
// Latency: n/a (wires only); every output seen here is registered inside flag_unit.
// Backpressure: none; stack misuse is reported on err rather than stalled.
//
// Ports (master = decoder/ALU side, slave = flag_unit):
//   upd_en/upd_mask/f_in  masked ALU update      ld_en/ld_sel/ld_val  single-flag load
//   mov_en                whole-word move         push/pop             save/restore stack
//   err_clr               clear sticky err        q/depth/full/empty/err  status out
interface flag_unit_if #(
  parameter int NFLAGS = 8,
  parameter int DEPTH  = 4
);
  localparam int SELW = (NFLAGS > 1) ? $clog2(NFLAGS) : 1;
  localparam int DW   = $clog2(DEPTH + 1);

  logic              upd_en;
  logic [NFLAGS-1:0] upd_mask;
  logic [NFLAGS-1:0] f_in;
  logic              ld_en;
  logic [SELW-1:0]   ld_sel;
  logic              ld_val;
  logic              mov_en;
  logic              push;
  logic              pop;
  logic              err_clr;
  logic [NFLAGS-1:0] q;
  logic [DW-1:0]     depth;
  logic              full;
  logic              empty;
  logic              err;

  modport master (
    output upd_en, upd_mask, f_in, ld_en, ld_sel, ld_val, mov_en, push, pop, err_clr,
    input  q, depth, full, empty, err
  );

  modport slave (
    input  upd_en, upd_mask, f_in, ld_en, ld_sel, ld_val, mov_en, push, pop, err_clr,
    output q, depth, full, empty, err
  );
endinterface

// File: rtl/flag_unit.sv
// Status-flag register with masked ALU update, single-flag load, move, forced-one bits and a LIFO save stack.
// Latency: 1 cycle; all effects appear on q/depth/err after the next rising clk edge.
// Backpressure: none; push-when-full, pop-when-empty and push+pop together are dropped and set sticky err.
//
// Ports: clk, rst_n (synchronous, active-low); bus (flag_unit_if.slave) carries every control and status signal.
module flag_unit #(
  parameter int                NFLAGS    = 8,
  parameter int                DEPTH     = 4,
  parameter logic [NFLAGS-1:0] FORCE_ONE = 8'h20,
  parameter logic [NFLAGS-1:0] RESET_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  flag_unit_if.slave  bus
);
  localparam int SELW = (NFLAGS > 1) ? $clog2(NFLAGS) : 1;
  localparam int DW   = $clog2(DEPTH + 1);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [SELW:0]   NFLAGS_L = NFLAGS[SELW:0];
  localparam logic [DW-1:0]   DEPTH_L  = DEPTH[DW-1:0];

  logic [NFLAGS-1:0] q_r;
  logic [NFLAGS-1:0] q_nxt;
  logic [DW-1:0]     depth_r;
  logic [DW-1:0]     top_idx;
  logic              err_r;
  logic              full_w;
  logic              empty_w;
  logic              push_ok;
  logic              pop_ok;
  logic              err_evt;
  logic [NFLAGS-1:0] stack [DEPTH];

  assign full_w  = (depth_r == DEPTH_L);
  assign empty_w = (depth_r == '0);

  // push and pop together cancel each other; both are then treated as misuse
  assign push_ok = bus.push & ~bus.pop & ~full_w;
  assign pop_ok  = bus.pop  & ~bus.push & ~empty_w;
  assign err_evt = (bus.push & bus.pop)
                 | (bus.push & ~bus.pop & full_w)
                 | (bus.pop  & ~bus.push & empty_w);

  assign top_idx = depth_r - 1'b1;

  always_comb begin
    q_nxt = q_r;
    if (pop_ok) begin
      q_nxt = stack[top_idx[AW-1:0]];
    end else if (bus.mov_en) begin
      q_nxt = bus.f_in;
    end else if (bus.ld_en && ({1'b0, bus.ld_sel} < NFLAGS_L)) begin
      q_nxt[bus.ld_sel] = bus.ld_val;
    end else if (bus.upd_en) begin
      q_nxt = (q_r & ~bus.upd_mask) | (bus.f_in & bus.upd_mask);
    end
    // forced bits survive every source, including restored stack entries
    q_nxt = q_nxt | FORCE_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r     <= RESET_VAL | FORCE_ONE;
      depth_r <= '0;
      err_r   <= 1'b0;
    end else begin
      q_r <= q_nxt;
      if (push_ok) begin
        depth_r <= depth_r + 1'b1;
      end else if (pop_ok) begin
        depth_r <= depth_r - 1'b1;
      end
      // a new error outranks a simultaneous clear
      if (err_evt) begin
        err_r <= 1'b1;
      end else if (bus.err_clr) begin
        err_r <= 1'b0;
      end
    end
  end

  // Stack contents need no reset; the saved value is q before this cycle's update.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      stack[depth_r[AW-1:0]] <= q_r;
    end
  end

  assign bus.q     = q_r;
  assign bus.depth = depth_r;
  assign bus.full  = full_w;
  assign bus.empty = empty_w;
  assign bus.err   = err_r;
endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: reset, update priorities, forced bit, stack push/pop and error cases.
// Latency: each vector is applied and checked one clk edge later.
// Backpressure: none exercised beyond stack misuse, which is checked through err.
module tb_flag_unit;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  flag_unit_if #(.NFLAGS(8), .DEPTH(4)) bus ();

  flag_unit #(
    .NFLAGS(8), .DEPTH(4), .FORCE_ONE(8'h20), .RESET_VAL(8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.upd_en   = 1'b0;
    bus.upd_mask = 8'h00;
    bus.f_in     = 8'h00;
    bus.ld_en    = 1'b0;
    bus.ld_sel   = 3'd0;
    bus.ld_val   = 1'b0;
    bus.mov_en   = 1'b0;
    bus.push     = 1'b0;
    bus.pop      = 1'b0;
    bus.err_clr  = 1'b0;
  endtask

  // one clock edge, then settle before sampling; inputs return to idle
  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic status(input string tag, input logic [7:0] eq, input logic [2:0] ed, input logic ee);
    chk({tag, ".q"}, 32'(bus.q), 32'(eq));
    chk({tag, ".depth"}, 32'(bus.depth), 32'(ed));
    chk({tag, ".err"}, 32'(bus.err), 32'(ee));
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    idle();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;

    // reset state
    status("reset", 8'h20, 3'd0, 1'b0);
    chk("reset.empty", 32'(bus.empty), 32'd1);
    chk("reset.full", 32'(bus.full), 32'd0);

    // masked update, single load, load to forced bit
    bus.upd_en = 1'b1; bus.upd_mask = 8'h05; bus.f_in = 8'hFF;
    cyc();
    chk("upd", 32'(bus.q), 32'h25);
    bus.ld_en = 1'b1; bus.ld_sel = 3'd3; bus.ld_val = 1'b1;
    cyc();
    chk("ld_c", 32'(bus.q), 32'h2D);
    bus.ld_en = 1'b1; bus.ld_sel = 3'd5; bus.ld_val = 1'b0;
    cyc();
    chk("ld_forced", 32'(bus.q), 32'h2D);

    // mov beats upd
    bus.mov_en = 1'b1; bus.upd_en = 1'b1; bus.f_in = 8'h0F; bus.upd_mask = 8'hFF;
    cyc();
    chk("mov_prio", 32'(bus.q), 32'h2F);

    // push saves pre-edge q while upd still applies; pop beats mov
    bus.mov_en = 1'b1; bus.f_in = 8'h21;
    cyc();
    chk("mov21", 32'(bus.q), 32'h21);
    bus.push = 1'b1; bus.upd_en = 1'b1; bus.upd_mask = 8'h01; bus.f_in = 8'h00;
    cyc();
    status("push_upd", 8'h20, 3'd1, 1'b0);
    bus.pop = 1'b1; bus.mov_en = 1'b1; bus.f_in = 8'h00;
    cyc();
    status("pop_mov", 8'h21, 3'd0, 1'b0);

    // fill the stack: saves 21,22,24,28
    bus.push = 1'b1; bus.mov_en = 1'b1; bus.f_in = 8'h02; cyc();
    bus.push = 1'b1; bus.mov_en = 1'b1; bus.f_in = 8'h04; cyc();
    bus.push = 1'b1; bus.mov_en = 1'b1; bus.f_in = 8'h08; cyc();
    bus.push = 1'b1; bus.mov_en = 1'b1; bus.f_in = 8'h10; cyc();
    status("fill", 8'h30, 3'd4, 1'b0);
    chk("fill.full", 32'(bus.full), 32'd1);
    chk("fill.empty", 32'(bus.empty), 32'd0);
    bus.push = 1'b1;
    cyc();
    status("push_full", 8'h30, 3'd4, 1'b1);
    bus.err_clr = 1'b1;
    cyc();
    chk("err_clr", 32'(bus.err), 32'd0);

    bus.pop = 1'b1; cyc(); status("pop3", 8'h28, 3'd3, 1'b0);
    bus.pop = 1'b1; cyc(); status("pop2", 8'h24, 3'd2, 1'b0);
    bus.pop = 1'b1; cyc(); status("pop1", 8'h22, 3'd1, 1'b0);
    bus.pop = 1'b1; cyc(); status("pop0", 8'h21, 3'd0, 1'b0);
    chk("pop0.empty", 32'(bus.empty), 32'd1);
    bus.pop = 1'b1;
    cyc();
    status("pop_empty", 8'h21, 3'd0, 1'b1);

    // error set wins over simultaneous clear; lower source applies on failed pop
    bus.err_clr = 1'b1; bus.pop = 1'b1; bus.upd_en = 1'b1; bus.upd_mask = 8'h08; bus.f_in = 8'hFF;
    cyc();
    status("clr_vs_set", 8'h29, 3'd0, 1'b1);
    bus.err_clr = 1'b1;
    cyc();
    chk("err_clr2", 32'(bus.err), 32'd0);

    // push+pop together at depth 2: ignored, err set, upd applies
    bus.push = 1'b1; bus.mov_en = 1'b1; bus.f_in = 8'h02; cyc();
    bus.push = 1'b1; bus.mov_en = 1'b1; bus.f_in = 8'h04; cyc();
    status("depth2", 8'h24, 3'd2, 1'b0);
    bus.push = 1'b1; bus.pop = 1'b1; bus.upd_en = 1'b1; bus.upd_mask = 8'h01; bus.f_in = 8'hFF;
    cyc();
    status("push_pop", 8'h25, 3'd2, 1'b1);
    bus.pop = 1'b1;
    cyc();
    status("pop_after_pp", 8'h22, 3'd1, 1'b1);

    // reset overrides a concurrent push
    rst_n = 1'b0; bus.push = 1'b1; bus.mov_en = 1'b1; bus.f_in = 8'hFF;
    cyc();
    rst_n = 1'b1;
    status("rst_push", 8'h20, 3'd0, 1'b0);
    chk("rst_push.empty", 32'(bus.empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
